// File: rtl/rv32_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder/loader.
package rv32_enc_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // fmt stays raw so out-of-range codes can be carried and flagged
    typedef struct packed {
        logic [2:0]        fmt;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [4:0]        rd;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [WORD_W-1:0] imm;
    } desc_t;

endpackage

// File: rtl/rv32_field_encoder.sv
// Packs one RV32I field descriptor into its 32-bit instruction word.
module rv32_field_encoder
    import rv32_enc_pkg::*;
(
    input  desc_t             desc,
    output logic [WORD_W-1:0] word,
    output logic              illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (desc.fmt)
            FMT_R: word = {desc.funct7, desc.rs2, desc.rs1, desc.funct3, desc.rd, desc.opcode};
            FMT_I: word = {desc.imm[11:0], desc.rs1, desc.funct3, desc.rd, desc.opcode};
            FMT_S: word = {desc.imm[11:5], desc.rs2, desc.rs1, desc.funct3,
                           desc.imm[4:0], desc.opcode};
            FMT_B: begin
                word    = {desc.imm[12], desc.imm[10:5], desc.rs2, desc.rs1, desc.funct3,
                           desc.imm[4:1], desc.imm[11], desc.opcode};
                illegal = desc.imm[0];
            end
            FMT_U: word = {desc.imm[31:12], desc.rd, desc.opcode};
            FMT_J: begin
                word    = {desc.imm[20], desc.imm[10:1], desc.imm[11], desc.imm[19:12],
                           desc.rd, desc.opcode};
                illegal = desc.imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams RV32I descriptors, encodes them and writes consecutive imem words.
module instr_encoder_loader
    import rv32_enc_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [2:0]        s_fmt,
    input  logic [6:0]        s_opcode,
    input  logic [2:0]        s_funct3,
    input  logic [6:0]        s_funct7,
    input  logic [4:0]        s_rd,
    input  logic [4:0]        s_rs1,
    input  logic [4:0]        s_rs2,
    input  logic [31:0]       s_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

    state_e              state_q;
    state_e              state_d;
    desc_t               desc;
    logic [WORD_W-1:0]   enc_word;
    logic                enc_illegal;
    logic                accept;
    logic                hit_limit;
    logic                new_session;
    logic [ADDR_W-1:0]   addr_q;
    logic [CNT_W-1:0]    acc_cnt_q;

    assign desc = '{fmt: s_fmt, opcode: s_opcode, funct3: s_funct3, funct7: s_funct7,
                    rd: s_rd, rs1: s_rs1, rs2: s_rs2, imm: s_imm};

    rv32_field_encoder u_enc (
        .desc    (desc),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // s_ready is a flop that mirrors state == LOAD
    assign accept      = s_valid & s_ready;
    assign hit_limit   = (acc_cnt_q == LAST_CNT);
    assign new_session = start & ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_LOAD;
            ST_LOAD:  if (accept && (s_last || hit_limit)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            s_ready <= (state_d == ST_LOAD);
            busy    <= (state_d == ST_LOAD);
            done    <= (state_d == ST_DONE);
        end
    end

    // Illegal descriptors are consumed but leave address and word_count untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            addr_q     <= BASE_ADDR;
            acc_cnt_q  <= '0;
            word_count <= '0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (new_session) begin
                addr_q     <= BASE_ADDR;
                acc_cnt_q  <= '0;
                word_count <= '0;
                err        <= 1'b0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
                if (enc_illegal) begin
                    err <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= addr_q;
                    imem_wdata <= enc_word;
                    addr_q     <= addr_q + ADDR_W'(4);
                    word_count <= word_count + 16'((word_count != 16'hFFFF) ? 1 : 0);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: default instance plus a MAX_WORDS=4 instance.
module tb_instr_encoder_loader;
    import rv32_enc_pkg::*;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    logic        clk, rst_n, start, s_valid, s_last;
    logic [2:0]  s_fmt, s_funct3;
    logic [6:0]  s_opcode, s_funct7;
    logic [4:0]  s_rd, s_rs1, s_rs2;
    logic [31:0] s_imm;

    logic        s_ready, imem_we, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] word_count;
    logic        s_ready4, imem_we4, busy4, done4, err4;
    logic [31:0] imem_addr4, imem_wdata4;
    logic [15:0] word_count4;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en  = 1'b1;
    bit   mon4_en = 1'b0;
    exp_t q[$];
    exp_t q4[$];

    instr_encoder_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_fmt(s_fmt), .s_opcode(s_opcode), .s_funct3(s_funct3),
        .s_funct7(s_funct7), .s_rd(s_rd), .s_rs1(s_rs1), .s_rs2(s_rs2), .s_imm(s_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .word_count(word_count)
    );

    instr_encoder_loader #(.MAX_WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready4),
        .s_last(s_last), .s_fmt(s_fmt), .s_opcode(s_opcode), .s_funct3(s_funct3),
        .s_funct7(s_funct7), .s_rd(s_rd), .s_rs1(s_rs1), .s_rs2(s_rs2), .s_imm(s_imm),
        .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
        .busy(busy4), .done(done4), .err(err4), .word_count(word_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-assembled reference instructions with their known encodings
    function automatic vec_t vec(input int i);
        vec_t v;
        v = '0;
        case (i)
            0:  begin v.fmt = FMT_R; v.op = OP_R; v.rd = 5'd3; v.rs1 = 5'd1; v.rs2 = 5'd2;
                      v.imm = 32'hDEADBEEF; v.word = 32'h002081B3; end
            1:  begin v.fmt = FMT_I; v.op = OP_I; v.rd = 5'd1; v.imm = 32'd5;
                      v.word = 32'h00500093; end
            2:  begin v.fmt = FMT_S; v.op = OP_S; v.f3 = 3'd2; v.rs1 = 5'd1; v.rs2 = 5'd2;
                      v.imm = 32'd8; v.word = 32'h0020A423; end
            3:  begin v.fmt = FMT_B; v.op = OP_B; v.rs1 = 5'd1; v.rs2 = 5'd2; v.imm = 32'd8;
                      v.word = 32'h00208463; end
            4:  begin v.fmt = FMT_J; v.op = OP_JAL; v.rd = 5'd1; v.imm = 32'd16;
                      v.word = 32'h010000EF; end
            5:  begin v.fmt = FMT_U; v.op = 7'b0110111; v.rd = 5'd5; v.imm = 32'h12345000;
                      v.f3 = 3'd7; v.f7 = 7'h7F; v.rs1 = 5'd31; v.rs2 = 5'd31;
                      v.word = 32'h123452B7; end
            6:  begin v.fmt = FMT_I; v.op = OP_LD; v.f3 = 3'd2; v.rd = 5'd6; v.rs1 = 5'd1;
                      v.imm = 32'd4; v.word = 32'h0040A303; end
            7:  begin v.fmt = FMT_J; v.op = OP_JAL; v.imm = 32'hFFFFFFFC;
                      v.word = 32'hFFDFF06F; end
            8:  begin v.fmt = FMT_B; v.op = OP_B; v.imm = 32'hFFFFFFFC;
                      v.word = 32'hFE000EE3; end
            9:  begin v.fmt = FMT_S; v.op = OP_S; v.f3 = 3'd2; v.rs1 = 5'd2; v.rs2 = 5'd5;
                      v.imm = 32'hFFFFFFFC; v.word = 32'hFE512E23; end
            10: begin v.fmt = FMT_R; v.op = OP_R; v.f7 = 7'h20; v.rd = 5'd5; v.rs1 = 5'd6;
                      v.rs2 = 5'd7; v.imm = 32'h0000FFFF; v.word = 32'h407302B3; end
            default: ;
        endcase
        return v;
    endfunction

    // Advance to the next falling edge and retire any observed writes against the scoreboards
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (mon_en && imem_we) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                e = q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.word || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL wr got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             imem_addr, imem_wdata, cyc, e.addr, e.word, e.cyc);
                end
            end
        end
        if (mon4_en && imem_we4) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL wr4_unexpected addr=%h data=%h", imem_addr4, imem_wdata4);
            end else begin
                e = q4.pop_front();
                if (imem_addr4 !== e.addr || imem_wdata4 !== e.word || cyc !== e.cyc) begin
                    bad++;
                    $display("FAIL wr4 got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                             imem_addr4, imem_wdata4, cyc, e.addr, e.word, e.cyc);
                end
            end
        end
    endtask

    task automatic apply(input vec_t v, input bit last);
        s_fmt = v.fmt; s_opcode = v.op; s_funct3 = v.f3; s_funct7 = v.f7;
        s_rd = v.rd; s_rs1 = v.rs1; s_rs2 = v.rs2; s_imm = v.imm; s_last = last;
    endtask

    // Present one descriptor, wait for ready, push the expected write, return after the accept edge
    task automatic put(input bit sel4, input vec_t v, input bit last, input bit exp_we,
                       input logic [31:0] exp_addr);
        exp_t e;
        int   n;
        apply(v, last);
        s_valid = 1'b1;
        n = 0;
        while (!(sel4 ? s_ready4 : s_ready) && n < 40) begin
            step();
            n++;
        end
        total++;
        if (!(sel4 ? s_ready4 : s_ready)) begin
            bad++;
            $display("FAIL put_timeout ready=0 want 1 after %0d cycles", n);
            s_valid = 1'b0;
            return;
        end
        if (exp_we) begin
            e.addr = exp_addr; e.word = v.word; e.cyc = cyc + 1;
            if (sel4) q4.push_back(e);
            else      q.push_back(e);
        end
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL wait_done done=%b want 1", done);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (q.size() !== 0) begin
            bad++;
            $display("FAIL %s_missing_writes pending=%0d want 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total++;
        if ({s_ready, imem_we, busy, done, err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b want 00000", {s_ready, imem_we, busy, done, err});
        end
        total++;
        if (imem_addr !== 32'h0 || imem_wdata !== 32'h0 || word_count !== 16'h0) begin
            bad++;
            $display("FAIL reset_data got addr=%h data=%h wc=%0d want 0 0 0",
                     imem_addr, imem_wdata, word_count);
        end
        rst_n = 1'b1;
        step();
        step();
        total++;
        if ({s_ready, busy, done} !== 3'b0) begin
            bad++;
            $display("FAIL idle_after_reset got %b want 000", {s_ready, busy, done});
        end
    endtask

    task automatic test_program();
        pulse_start();
        total++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL prog_busy got busy=%b ready=%b want 1 1", busy, s_ready);
        end
        for (int i = 0; i < 5; i++) begin
            put(1'b0, vec(i), (i == 4), 1'b1, 32'(i * 4));
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i != 4) step();
        end
        wait_done();
        total++;
        if (word_count !== 16'd5 || err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL prog_end got wc=%0d err=%b busy=%b want 5 0 0", word_count, err, busy);
        end
        check_drained("prog");
    endtask

    task automatic test_illegal();
        vec_t v;
        pulse_start();
        v = vec(3);
        v.imm = 32'd3;
        put(1'b0, v, 1'b0, 1'b0, 32'h0);
        v = vec(0);
        v.fmt = 3'd7;
        put(1'b0, v, 1'b0, 1'b0, 32'h0);
        total++;
        if (err !== 1'b1 || word_count !== 16'd0) begin
            bad++;
            $display("FAIL illegal_flag got err=%b wc=%0d want 1 0", err, word_count);
        end
        put(1'b0, vec(1), 1'b1, 1'b1, 32'h0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done();
        total++;
        if (err !== 1'b1 || word_count !== 16'd1) begin
            bad++;
            $display("FAIL illegal_end got err=%b wc=%0d want 1 1", err, word_count);
        end
        check_drained("illegal");
    endtask

    task automatic test_back_to_back();
        pulse_start();
        total++;
        if (err !== 1'b0 || word_count !== 16'd0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL restart got err=%b wc=%0d ready=%b want 0 0 1", err, word_count, s_ready);
        end
        for (int i = 5; i <= 10; i++) put(1'b0, vec(i), (i == 10), 1'b1, 32'((i - 5) * 4));
        total++;
        if (s_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_drop got ready=%b busy=%b want 0 0", s_ready, busy);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        step();
        total++;
        if (done !== 1'b1 || word_count !== 16'd6) begin
            bad++;
            $display("FAIL b2b_end got done=%b wc=%0d want 1 6", done, word_count);
        end
        check_drained("b2b");
    endtask

    task automatic test_max_words();
        mon_en  = 1'b0;
        mon4_en = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) put(1'b1, vec(i), 1'b0, 1'b1, 32'(i * 4));
        apply(vec(4), 1'b0);
        total++;
        if (s_ready4 !== 1'b0 || done4 !== 1'b0) begin
            bad++;
            $display("FAIL max_drain got ready=%b done=%b want 0 0", s_ready4, done4);
        end
        step();
        total++;
        if (done4 !== 1'b1 || s_ready4 !== 1'b0 || word_count4 !== 16'd4) begin
            bad++;
            $display("FAIL max_done got done=%b ready=%b wc=%0d want 1 0 4",
                     done4, s_ready4, word_count4);
        end
        step();
        s_valid = 1'b0;
        total++;
        if (q4.size() !== 0) begin
            bad++;
            $display("FAIL max_missing_writes pending=%0d want 0", q4.size());
        end
        mon4_en = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        apply(vec(2), 1'b0);
        s_valid = 1'b1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_ready got %b want 1", s_ready);
        end
        step();
        total++;
        if (imem_we !== 1'b1) begin
            bad++;
            $display("FAIL midrst_inflight got we=%b want 1", imem_we);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== 32'h0 ||
            imem_wdata !== 32'h0 || word_count !== 16'h0) begin
            bad++;
            $display("FAIL midrst_clear got flags=%b addr=%h data=%h wc=%0d want 0",
                     {s_ready, imem_we, busy, done, err}, imem_addr, imem_wdata, word_count);
        end
        s_valid = 1'b0;
        step();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        step();
        total++;
        if ({s_ready, busy, done, imem_we} !== 4'b0) begin
            bad++;
            $display("FAIL midrst_idle got %b want 0000", {s_ready, busy, done, imem_we});
        end
        pulse_start();
        put(1'b0, vec(6), 1'b1, 1'b1, 32'h0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_done();
        total++;
        if (word_count !== 16'd1) begin
            bad++;
            $display("FAIL midrst_wc got %0d want 1", word_count);
        end
        check_drained("midrst");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0;
        apply('0, 1'b0);
        test_reset();
        test_program();
        test_illegal();
        test_back_to_back();
        test_max_words();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
